// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, branch flush and instruction-fetch wait control.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned IMEM_TIMEOUT      = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic       ex_branch_taken_i,
    input  logic       imem_ready_i,
    output logic       pc_write_o,
    output logic       if_id_write_o,
    output logic       if_id_flush_o,
    output logic       id_ex_bubble_o,
    output logic [1:0] state_o,
    output logic       fetch_error_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StImemWait  = 2'd2,
        StBad       = 2'd3
    } state_e;

    localparam logic [7:0] TimeoutVal = 8'(IMEM_TIMEOUT);
    localparam logic [1:0] StallLoad  = 2'(LOAD_STALL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       fetch_error_q, fetch_error_d;
    logic       hazard;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;

    assign hazard = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_error_d = fetch_error_q;

        if (ex_branch_taken_i) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = StRun;
            stall_cnt_d  = 2'd0;
            wait_cnt_d   = 8'd0;
        end else begin
            case (state_q)
                StRun: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d     = StLoadStall;
                            stall_cnt_d = StallLoad;
                        end
                    end else if (!imem_ready_i) begin
                        // IF/ID is loaded with a NOP while fetch is pending
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if_id_flush = 1'b1;
                        state_d     = StImemWait;
                        wait_cnt_d  = 8'd1;
                    end
                end
                StLoadStall: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (stall_cnt_q <= 2'd1) begin
                        state_d     = StRun;
                        stall_cnt_d = 2'd0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 2'd1;
                    end
                end
                StImemWait: begin
                    if (!imem_ready_i) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if_id_flush = 1'b1;
                        if (wait_cnt_q == TimeoutVal) begin
                            fetch_error_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d    = StRun;
                        wait_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d     = StRun;
                    stall_cnt_d = 2'd0;
                    wait_cnt_d  = 8'd0;
                end
            endcase
        end
    end

    // Controls are forced inactive for as long as reset is held
    assign pc_write_o     = pc_write     & rst_ni;
    assign if_id_write_o  = if_id_write  & rst_ni;
    assign if_id_flush_o  = if_id_flush  & rst_ni;
    assign id_ex_bubble_o = id_ex_bubble & rst_ni;
    assign state_o        = state_q;
    assign fetch_error_o  = fetch_error_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StRun;
            stall_cnt_q   <= 2'd0;
            wait_cnt_q    <= 8'd0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_error_q <= fetch_error_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (id_ex_bubble && !ex_branch_taken_i) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ex_branch_taken_i) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: three parameterisations share one stimulus stream; vector table,
// directed multi-cycle sequences and randomized cycles checked against a behavioural model.
module tb_hazard_sequencer;

    localparam int N = 3;
    localparam int unsigned LS [N] = '{1, 3, 2};
    localparam int unsigned TO [N] = '{255, 3, 5};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, br_taken, imem_ready;

    logic       pc_write    [N];
    logic       if_id_write [N];
    logic       if_id_flush [N];
    logic       id_ex_bubble[N];
    logic [1:0] dut_state   [N];
    logic       fetch_error [N];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles[N];
    logic [31:0] flush_count [N];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hazard_sequencer #(
            .LOAD_STALL_CYCLES(LS[g]),
            .IMEM_TIMEOUT     (TO[g])
        ) u_dut (
            .clk_i            (clk),
            .rst_ni           (rst_n),
            .id_rs_i          (id_rs),
            .id_rt_i          (id_rt),
            .id_uses_rt_i     (id_uses_rt),
            .ex_mem_read_i    (ex_mem_read),
            .ex_rt_i          (ex_rt),
            .ex_branch_taken_i(br_taken),
            .imem_ready_i     (imem_ready),
            .pc_write_o       (pc_write[g]),
            .if_id_write_o    (if_id_write[g]),
            .if_id_flush_o    (if_id_flush[g]),
            .id_ex_bubble_o   (id_ex_bubble[g]),
            .state_o          (dut_state[g]),
            .fetch_error_o    (fetch_error[g])
`ifdef HAZARD_PERF_CNT_EN
            ,
            .stall_cycles_o   (stall_cycles[g]),
            .flush_count_o    (flush_count[g])
`endif
        );
    end

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] CtlNorm  = 4'b1100;
    localparam logic [3:0] CtlStall = 4'b0001;
    localparam logic [3:0] CtlImem  = 4'b0010;
    localparam logic [3:0] CtlBr    = 4'b1011;

    function automatic logic [3:0] ctl(int i);
        return {pc_write[i], if_id_write[i], if_id_flush[i], id_ex_bubble[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                          input logic u, input logic mr, input logic [4:0] xr,
                          input logic b, input logic rdy);
        rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = u;
        ex_mem_read = mr; ex_rt = xr; br_taken = b; imem_ready = rdy;
    endtask

    task automatic idle();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int stall_left;  // extra stall cycles still owed
        bit waiting;     // fetch outstanding
        int waited;      // fetch wait cycles counted so far
        bit err;
        int stalls;
        int flushes;
    } mdl_t;

    mdl_t m[N];

    function automatic bit hz();
        return ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic logic [3:0] m_ctl(int i);
        if (!rst_n) return 4'b0000;
        if (br_taken) return CtlBr;
        if (m[i].stall_left > 0 || (!m[i].waiting && hz())) return CtlStall;
        if (!imem_ready) return CtlImem;
        return CtlNorm;
    endfunction

    function automatic logic [1:0] m_state(int i);
        if (m[i].stall_left > 0) return 2'd1;
        if (m[i].waiting) return 2'd2;
        return 2'd0;
    endfunction

    task automatic m_step(input int i);
        logic [3:0] c;
        if (!rst_n) begin
            m[i] = '{0, 1'b0, 0, 1'b0, 0, 0};
            return;
        end
        c = m_ctl(i);
        if (c[0] && !br_taken) m[i].stalls++;
        if (br_taken) m[i].flushes++;
        if (br_taken) begin
            m[i].stall_left = 0; m[i].waiting = 1'b0; m[i].waited = 0;
        end else if (m[i].stall_left > 0) begin
            m[i].stall_left--;
        end else if (!m[i].waiting && hz()) begin
            m[i].stall_left = int'(LS[i]) - 1;
        end else if (m[i].waiting) begin
            if (imem_ready) begin
                m[i].waiting = 1'b0; m[i].waited = 0;
            end else begin
                if (m[i].waited == int'(TO[i])) m[i].err = 1'b1;
                else m[i].waited++;
            end
        end else if (!imem_ready) begin
            m[i].waiting = 1'b1; m[i].waited = 1;
        end
    endtask

    // ---------------- vector table (instance 0: 1-cycle stall) ----------------
    typedef struct {
        logic       mr;
        logic [4:0] xr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       u;
        logic       b;
        logic       rdy;
        logic [3:0] ctl;
        logic [1:0] st;   // state after the edge
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, CtlNorm,  2'd0};
        tbl[1]  = '{1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, CtlStall, 2'd0};
        tbl[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, CtlNorm,  2'd0};
        tbl[3]  = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b1, CtlNorm,  2'd0};
        tbl[4]  = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b1, CtlStall, 2'd0};
        tbl[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, CtlImem,  2'd2};
        tbl[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, CtlImem,  2'd2};
        tbl[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, CtlNorm,  2'd0};
        tbl[8]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, CtlStall, 2'd0};
        tbl[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, CtlImem,  2'd2};
        tbl[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, CtlBr,    2'd0};
        tbl[11] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, CtlBr,    2'd0};

        // reset state and gated controls
        set_in(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("reset_ctl", 32'(ctl(i)), 32'd0);
        edge1();
        idle();
        for (int i = 0; i < N; i++) begin
            chk("reset_state", 32'(dut_state[i]), 32'd0);
            chk("reset_err", 32'(fetch_error[i]), 32'd0);
        end

        for (int v = 0; v < 12; v++) begin
            set_in(1'b1, tbl[v].rs, tbl[v].rt, tbl[v].u, tbl[v].mr, tbl[v].xr, tbl[v].b,
                   tbl[v].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", v), 32'(ctl(0)), 32'(tbl[v].ctl));
            edge1();
            chk($sformatf("vec%0d_state", v), 32'(dut_state[0]), 32'(tbl[v].st));
        end

        // 3-cycle load-use stall, hazard dropped after the first cycle
        do_reset();
        set_in(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        @(negedge clk);
        chk("ls3_c0_ctl", 32'(ctl(1)), 32'(CtlStall));
        chk("ls3_c0_state", 32'(dut_state[1]), 32'd0);
        edge1();
        idle();
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("ls3_c%0d_ctl", c), 32'(ctl(1)), 32'(CtlStall));
            chk($sformatf("ls3_c%0d_state", c), 32'(dut_state[1]), 32'd1);
            edge1();
        end
        @(negedge clk);
        chk("ls3_end_ctl", 32'(ctl(1)), 32'(CtlNorm));
        chk("ls3_end_state", 32'(dut_state[1]), 32'd0);
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ls3_rt0_ctl", 32'(ctl(1)), 32'(CtlNorm));
        edge1();
        chk("ls3_rt0_state", 32'(dut_state[1]), 32'd0);

        // fetch wait: instance 0 (timeout 255) and instance 1 (timeout 3)
        do_reset();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk($sformatf("wait%0d_ctl0", e), 32'(ctl(0)), 32'(CtlImem));
            chk($sformatf("wait%0d_ctl1", e), 32'(ctl(1)), 32'(CtlImem));
            edge1();
            chk($sformatf("wait%0d_state0", e), 32'(dut_state[0]), 32'd2);
            chk($sformatf("wait%0d_err0", e), 32'(fetch_error[0]), 32'd0);
            chk($sformatf("wait%0d_err1", e), 32'(fetch_error[1]), (e >= 4) ? 32'd1 : 32'd0);
        end
        idle();
        @(negedge clk);
        chk("wait_rdy_ctl0", 32'(ctl(0)), 32'(CtlNorm));
        edge1();
        chk("wait_rdy_state0", 32'(dut_state[0]), 32'd0);
        chk("wait_rdy_err1", 32'(fetch_error[1]), 32'd1);
        edge1();
        chk("err_sticky", 32'(fetch_error[1]), 32'd1);
        do_reset();
        chk("err_cleared", 32'(fetch_error[1]), 32'd0);

        // branch during LOAD_STALL, then during IMEM_WAIT
        set_in(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        edge1();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        chk("br_stall_pre_state", 32'(dut_state[1]), 32'd1);
        chk("br_stall_ctl", 32'(ctl(1)), 32'(CtlBr));
        edge1();
        chk("br_stall_state", 32'(dut_state[1]), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("br_stall_flushes", flush_count[1], 32'd1);
        chk("br_stall_stalls", stall_cycles[1], 32'd1);
`endif
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        edge1();
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("br_wait_pre_state", 32'(dut_state[1]), 32'd2);
        chk("br_wait_ctl", 32'(ctl(1)), 32'(CtlBr));
        edge1();
        chk("br_wait_state", 32'(dut_state[1]), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("br_wait_flushes", flush_count[1], 32'd2);
`endif

        // reset asserted mid-stall
        do_reset();
        set_in(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        edge1();
        chk("rst_stall_pre", 32'(dut_state[1]), 32'd1);
        set_in(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_stall_ctl", 32'(ctl(1)), 32'd0);
        edge1();
        idle();
        chk("rst_stall_state", 32'(dut_state[1]), 32'd0);
        @(negedge clk);
        chk("rst_stall_norm", 32'(ctl(1)), 32'(CtlNorm));
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_stall_perf", stall_cycles[1], 32'd0);
`endif
        edge1();
        chk("rst_stall_state2", 32'(dut_state[1]), 32'd0);

        // randomized cycles against the model
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) m_step(i);
        edge1();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit any_wait;
            any_wait = 1'b0;
            for (int i = 0; i < N; i++) any_wait |= m[i].waiting;
            set_in(($urandom_range(0, 99) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom) & !any_wait,
                   5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) != 0));
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rnd_ctl%0d", i), 32'(ctl(i)), 32'(m_ctl(i)));
                m_step(i);
            end
            edge1();
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rnd_state%0d", i), 32'(dut_state[i]), 32'(m_state(i)));
                chk($sformatf("rnd_err%0d", i), 32'(fetch_error[i]), 32'(m[i].err));
`ifdef HAZARD_PERF_CNT_EN
                chk($sformatf("rnd_stalls%0d", i), stall_cycles[i], 32'(m[i].stalls));
                chk($sformatf("rnd_flushes%0d", i), flush_count[i], 32'(m[i].flushes));
`endif
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter SHALL be LOAD_STALL_CYCLES, default 1, load-use bubble length in cycles; legal range 1..3.
REQ-002 Parameter SHALL be IMEM_TIMEOUT, default 255, number of IMEM_WAIT cycles before fetch_error sets; legal range 1..255.
REQ-003 Port SHALL be clk  input  1  clock, all logic on rising edge.
REQ-004 Port SHALL be reset  input  1  reset, synchronous, active-low.
REQ-005 Ports SHALL be id_rs, id_rt  input  5 each  source registers of the instruction held in IF/ID.
REQ-006 Port SHALL be id_uses_rt  input  1  ID instruction reads rt.
REQ-007 Ports SHALL be ex_mem_read  input  1 and ex_rt  input  5  load flag and destination of the instruction in ID/EX.
REQ-008 Ports SHALL be ex_branch_taken  input  1 and imem_ready  input  1  branch redirect from EX; fetch data valid.
REQ-009 Outputs SHALL be pc_write, if_id_write, if_id_flush, id_ex_bubble  1 each  PC enable, IF/ID enable, IF/ID load-NOP, ID/EX load-NOP.
REQ-010 Outputs SHALL be state  2  FSM encoding, and fetch_error  1  sticky fetch timeout.

Function
REQ-011 The FSM SHALL have the states RUN=0, LOAD_STALL=1, IMEM_WAIT=2; encoding 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-012 A load-use hazard SHALL be ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-013 The four control outputs SHALL be combinational from the current state and inputs; the priority SHALL be branch, then load-use/LOAD_STALL, then imem_ready=0, then normal.
REQ-014 Branch (ex_branch_taken=1, any state): pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_write=0, next=RUN, and the wait and stall counters SHALL clear.
REQ-015 Hazard in RUN: pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle; next state SHALL be LOAD_STALL if LOAD_STALL_CYCLES>1, otherwise RUN.
REQ-016 LOAD_STALL SHALL repeat the REQ-015 outputs for exactly LOAD_STALL_CYCLES-1 cycles using a down-counter, then go to RUN; the hazard inputs SHALL be ignored while in this state.
REQ-017 imem_ready=0 in RUN with no branch and no hazard: pc_write=0, if_id_flush=1, id_ex_bubble=0; next=IMEM_WAIT, and the wait counter SHALL be loaded with 1.
REQ-018 In IMEM_WAIT with imem_ready=0, the REQ-017 outputs SHALL hold and the wait counter SHALL increment, saturating at IMEM_TIMEOUT; fetch_error SHALL set on the edge where the counter equals IMEM_TIMEOUT and stay set until reset.
REQ-019 In IMEM_WAIT with imem_ready=1, the normal outputs SHALL apply and next=RUN; the wait counter SHALL clear.
REQ-020 Normal outputs SHALL be pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-021 When a hazard and imem_ready=0 occur together in RUN, the load-use stall SHALL win; imem_ready SHALL be re-evaluated on return to RUN.

Reset
REQ-022 With reset=0 at a rising edge, the block SHALL set state=RUN, clear all counters, and clear fetch_error.
REQ-023 While reset=0, pc_write, if_id_write, if_id_flush and id_ex_bubble SHALL all be 0, regardless of the other inputs.
REQ-024 A reset asserted mid-stall or mid-wait SHALL abort it with no residual cycles after release.

Configuration
REQ-025 With HAZARD_PERF_CNT_EN defined, the block SHALL add the outputs stall_cycles and flush_count, each 32 bits, wrapping, and reset to 0.
REQ-026 stall_cycles SHALL increment on every cycle with id_ex_bubble=1 that is not caused by a branch; flush_count SHALL increment once per branch cycle.
REQ-027 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 ex_mem_read=1, ex_rt=8, id_rs=8, LOAD_STALL_CYCLES=1 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; state stays RUN.
REQ-029 Same hazard with LOAD_STALL_CYCLES=3 and the hazard inputs dropped after cycle 1 -> 3 stall cycles, state sequence 0,1,1,0; with ex_rt=0 -> no stall.
REQ-030 imem_ready=0 for 4 cycles, IMEM_TIMEOUT=255 -> if_id_flush=1 for 4 cycles, state=2, fetch_error=0; ready returns -> normal outputs, state=0.
REQ-031 IMEM_TIMEOUT=3, imem_ready held at 0 -> fetch_error=1 after the 3rd wait edge and still set after imem_ready=1; cleared only by reset.
REQ-032 ex_branch_taken=1 during LOAD_STALL and also during IMEM_WAIT -> if_id_flush=1, id_ex_bubble=1, pc_write=1, next state=0; with macro, flush_count +1 per branch.
REQ-033 reset=0 asserted in LOAD_STALL -> all four controls 0 while low; after release, state=0, counters 0, and normal outputs the next cycle.
